lap_recorder: RTL and testbench

Downstream companion to the stopwatch counter. It samples the stopwatch `count` on each `lap` request and computes the elapsed time since the previous lap, modulo MAX+1. It queues these split times in a small first-word-fall-through FIFO. A display or host interface drains the FIFO through a valid/ready handshake.

---
 rtl/lap_recorder_if.sv | 29 ++
 rtl/lap_recorder.sv | 93 +++++++++
 tb/tb_lap_recorder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lap_recorder_if.sv
// Bus bundle between the lap recorder and its producer/consumer.
// The master drives the stopwatch sample, lap/clear controls and consumer ready.
interface lap_recorder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] count;
  logic                  lap;
  logic                  clear;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  full;
  logic                  empty;
  logic [LevelW-1:0]     level;
  logic                  overflow;

  modport master (
    output count, lap, clear, dout_ready,
    input  dout, dout_valid, full, empty, level, overflow
  );

  modport slave (
    input  count, lap, clear, dout_ready,
    output dout, dout_valid, full, empty, level, overflow
  );
endinterface

// File: rtl/lap_recorder.sv
// Records split times (count delta since previous lap, modulo MAX+1) into a
// small first-word-fall-through FIFO drained through a valid/ready handshake.
module lap_recorder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX        = 99,
  parameter int unsigned DEPTH      = 4
) (
  input  logic          clk,
  input  logic          resetn,
  lap_recorder_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH:0] Modulus = (DATA_WIDTH + 1)'(MAX + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic [DATA_WIDTH-1:0] mark_q, mark_d;
  logic                  overflow_q, overflow_d;

  logic                  full, empty, push, pop;
  logic [DATA_WIDTH:0]   delta_ext;
  logic                  unused_delta_msb;

  assign empty = (level_q == '0);
  assign full  = (level_q == LevelW'(DEPTH));
  assign pop   = !bus.clear && !empty && bus.dout_ready;
  // A pop in the same cycle frees the slot, so a lap into a full FIFO still lands.
  assign push  = !bus.clear && bus.lap && (!full || pop);

  always_comb begin
    if (bus.count >= mark_q) begin
      delta_ext = {1'b0, bus.count} - {1'b0, mark_q};
    end else begin
      delta_ext = {1'b0, bus.count} + Modulus - {1'b0, mark_q};
    end
  end
  assign unused_delta_msb = delta_ext[DATA_WIDTH];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    mark_d     = mark_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      mark_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (bus.lap) mark_d = bus.count;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        level_d = level_q + LevelW'(1);
      end else if (!push && pop) begin
        level_d = level_q - LevelW'(1);
      end
      if (bus.lap && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mark_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mark_q     <= mark_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; dout masking on empty hides stale contents.
  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= delta_ext[DATA_WIDTH-1:0];
  end

  assign bus.dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.dout_valid = !empty;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder (DATA_WIDTH=16, MAX=99, DEPTH=4).
module tb_lap_recorder;
  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lap_recorder_if #(.DATA_WIDTH(16), .DEPTH(4)) bus ();

  lap_recorder #(
    .DATA_WIDTH(16),
    .MAX       (99),
    .DEPTH     (4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_lap(input int c);
    bus.count = 16'(c);
    bus.lap   = 1'b1;
    step();
    bus.lap   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.dout_valid), 0);
    check({tag, "_empty"}, 32'(bus.empty), 1);
    check({tag, "_full"}, 32'(bus.full), 0);
    check({tag, "_level"}, 32'(bus.level), 0);
    check({tag, "_dout"}, 32'(bus.dout), 0);
    check({tag, "_ovf"}, 32'(bus.overflow), 0);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.count      = 16'd50;
    bus.lap        = 1'b1;
    bus.clear      = 1'b0;
    bus.dout_ready = 1'b0;
    step();
    step();
    resetn  = 1'b1;
    bus.lap = 1'b0;
    check_idle("reset");

    // Ready while empty does nothing
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    check("ready_empty_level", 32'(bus.level), 0);

    // Basic splits
    do_lap(10);
    check("basic_first_valid", 32'(bus.dout_valid), 1);
    check("basic_first_dout", 32'(bus.dout), 10);
    do_lap(25);
    do_lap(40);
    check("basic_level", 32'(bus.level), 3);
    bus.dout_ready = 1'b1;
    check("basic_head0", 32'(bus.dout), 10);
    step();
    check("basic_head1", 32'(bus.dout), 15);
    step();
    check("basic_head2", 32'(bus.dout), 15);
    step();
    check("basic_drained", 32'(bus.empty), 1);
    check("basic_drained_dout", 32'(bus.dout), 0);
    bus.dout_ready = 1'b0;

    // Wrap-around and zero split (mark = 40)
    do_lap(90);
    do_lap(5);
    do_lap(90);
    do_lap(90);
    check("wrap_level", 32'(bus.level), 4);
    bus.dout_ready = 1'b1;
    check("wrap_e0", 32'(bus.dout), 50);
    step();
    check("wrap_e1", 32'(bus.dout), 15);
    step();
    check("wrap_e2", 32'(bus.dout), 85);
    step();
    check("wrap_e3_zero", 32'(bus.dout), 0);
    check("wrap_e3_valid", 32'(bus.dout_valid), 1);
    step();
    check("wrap_empty", 32'(bus.empty), 1);
    bus.dout_ready = 1'b0;

    // Full / overflow (mark = 90)
    do_lap(95);
    do_lap(3);
    do_lap(10);
    do_lap(30);
    check("full_flag", 32'(bus.full), 1);
    check("full_no_ovf_yet", 32'(bus.overflow), 0);
    do_lap(31);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_level", 32'(bus.level), 4);
    check("ovf_head", 32'(bus.dout), 5);
    // Lap+pop while full: dropped lap still moved mark to 31, so split is 9
    bus.dout_ready = 1'b1;
    do_lap(40);
    check("pushpop_level", 32'(bus.level), 4);
    check("pushpop_full", 32'(bus.full), 1);
    check("pushpop_head", 32'(bus.dout), 8);
    step();
    check("pushpop_e1", 32'(bus.dout), 7);
    step();
    check("pushpop_e2", 32'(bus.dout), 20);
    step();
    check("pushpop_tail", 32'(bus.dout), 9);
    step();
    check("pushpop_empty", 32'(bus.empty), 1);
    check("ovf_sticky", 32'(bus.overflow), 1);
    bus.dout_ready = 1'b0;

    // Clear mid-operation
    do_lap(45);
    do_lap(50);
    check("preclear_level", 32'(bus.level), 2);
    bus.clear      = 1'b1;
    bus.dout_ready = 1'b1;
    do_lap(60);
    bus.clear      = 1'b0;
    bus.dout_ready = 1'b0;
    check_idle("clear");
    do_lap(7);
    check("clear_next_split", 32'(bus.dout), 7);
    check("clear_next_level", 32'(bus.level), 1);

    // Reset mid-operation
    do_lap(10);
    do_lap(12);
    check("prereset_level", 32'(bus.level), 3);
    resetn    = 1'b0;
    bus.count = 16'd60;
    bus.lap   = 1'b1;
    step();
    resetn  = 1'b1;
    bus.lap = 1'b0;
    check_idle("midreset");
    do_lap(20);
    check("midreset_next_split", 32'(bus.dout), 20);

    // Back-to-back laps with a running count (mark = 20)
    bus.lap = 1'b1;
    for (int i = 21; i <= 23; i++) begin
      bus.count = 16'(i);
      step();
    end
    bus.lap        = 1'b0;
    check("b2b_level", 32'(bus.level), 4);
    bus.dout_ready = 1'b1;
    step();
    check("b2b_e1", 32'(bus.dout), 1);
    step();
    check("b2b_e2", 32'(bus.dout), 1);
    step();
    check("b2b_e3", 32'(bus.dout), 1);
    bus.dout_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
